snoop_bus_sequencer: RTL
========================

# snoop_bus_sequencer

Arbiter and transaction sequencer for the shared snooping bus between the three cache controllers and main memory in the MSI coherence system. Each cache posts a bus message (read miss, write miss, invalidate) with an address. The block grants the bus to one cache at a time and steps the transaction through address broadcast, snoop, optional dirty-line write-back and response. It replaces ad-hoc step counting with an explicit state machine and fair arbitration.

## Interface
- ADDR_W, 3, memory/bus address width (8-word memory)
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- req_msg  in  6  per-cache request, 2 bits per cache {c2,c1,c0}; 00 none, 01 write miss, 10 read miss, 11 invalidate
- req_addr  in  3*ADDR_W  per-cache request address, packed {c2,c1,c0}
- wb_req  in  3  one-hot snoop response: cache holds the bus address Modified and must write back
- grant  out  3  one-hot bus owner; 000 when idle
- bus_msg  out  2  message broadcast to snoopers; 00 outside ADDR
- bus_addr  out  ADDR_W  latched transaction address
- mem_we  out  1  memory write strobe for write-back data
- wb_src  out  2  index of cache driving write-back data (valid while mem_we)
- done  out  3  one-hot, one-cycle completion pulse to the grantee
- proto_err  out  1  sticky: more than one wb_req bit seen in SNOOP

## Operation
- States: IDLE, ADDR, SNOOP, WB, RESP.
- IDLE: if any req_msg slot is non-zero, pick a winner, latch its msg/addr, set grant, go to ADDR.
- ADDR: bus_msg = latched msg; bus_addr valid. Go to SNOOP.
- SNOOP: sample wb_req with the grantee's bit masked.
  - Any bit set and msg is 01/10: record the lowest set index as wb_src, go to WB.
  - Otherwise go to RESP.
  - Invalidate (11) never enters WB. wb_req is ignored for invalidates.
  - Two or more unmasked bits: set proto_err, use the lowest index.
- WB: mem_we = 1, write address = bus_addr, wb_src driven. Go to RESP.
- RESP: done[grantee] = 1. Memory read data for bus_addr is valid on the data bus this cycle. Go to IDLE, clear grant.
- Arbitration: round-robin. Pointer resets to 0. Search order starts at the pointer. After a grant to i, pointer = (i+1) mod 3.
- Latched msg/addr are frozen for the whole transaction. Changes on req_* are ignored until IDLE.
- A requester clears its req_msg on the edge that ends its done cycle. If the request is still non-zero in IDLE, it is treated as a new request.
- Reset at any point: state IDLE; grant, bus_msg, bus_addr, mem_we, wb_src, done = 0; pointer = 0; proto_err = 0.

## Timing
- All outputs are registered.
- Request visible before edge k: grant and ADDR in cycle k+1.
- Without write-back, done is asserted in cycle k+3. With write-back, done is asserted in cycle k+4.
- Minimum one IDLE cycle between transactions. Back-to-back throughput is 1 transaction per 4 cycles without write-back, 5 with.
- Simultaneous requests: exactly one grant per IDLE decision. The others wait; with all three requesting continuously, each waits at most 2 transactions.
- wb_req is only meaningful in SNOOP. It is ignored in every other state.

## Configuration
- SNOOP_ARB_FIXED_PRIO_EN defined: fixed priority, cache 0 > cache 1 > cache 2. Pointer logic is removed and starvation is permitted.
- Undefined (default): round-robin as above.

## Structure
- Package snoop_bus_pkg: message encodings (MSG_EMPTY, MSG_WRITE_MISS, MSG_READ_MISS, MSG_INVALIDATE), state enum, NUM_CACHES = 3.
- Sub-module rr_arbiter3: request vector plus pointer in, one-hot winner out, pointer update. The fixed-priority variant is selected by the macro inside it.

## Test plan
- After reset: all outputs 0. Cache 1 requests read miss at addr 5, no wb_req.
  - Expected: grant 010, then bus_msg 10 with bus_addr 5, then SNOOP, then done 010, total 3 cycles after grant; mem_we never asserted.
- Cache 0 requests write miss at addr 2, cache 2 asserts wb_req in SNOOP.
  - Expected: WB cycle with mem_we 1, bus_addr 2, wb_src 2, then done 001.
- All three request simultaneously and repeatedly.
  - Expected: grant order 001, 010, 100, 001.
  - With SNOOP_ARB_FIXED_PRIO_EN: 001 every time.
- Cache 2 requests invalidate at addr 7 while caches 0 and 1 assert wb_req in SNOOP.
  - Expected: no WB cycle, proto_err stays 0, done 100.
- Read miss from cache 0 with wb_req = 110.
  - Expected: proto_err set, wb_src 1, and proto_err holds until reset.
- Reset asserted during WB.
  - Expected: next cycle all outputs 0 and state IDLE; a pending request from cache 1 is then granted first (pointer 0, cache 0 idle).

Source files
------------

// File: rtl/snoop_bus_pkg.sv
// Shared encodings and types for the snooping-bus sequencer.
package snoop_bus_pkg;

  localparam int unsigned NUM_CACHES = 3;

  typedef enum logic [1:0] {
    MSG_EMPTY      = 2'b00,
    MSG_WRITE_MISS = 2'b01,
    MSG_READ_MISS  = 2'b10,
    MSG_INVALIDATE = 2'b11
  } msg_e;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StSnoop,
    StWb,
    StResp
  } state_e;

  // Lowest set index; callers only use it with a non-zero vector.
  function automatic logic [1:0] lowest_idx(logic [2:0] v);
    if (v[0]) begin
      return 2'd0;
    end else if (v[1]) begin
      return 2'd1;
    end
    return 2'd2;
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way bus arbiter: round-robin by default, fixed priority (0 > 1 > 2)
// when SNOOP_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter3
  import snoop_bus_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [2:0] req_i,
  input  logic       advance_i,
  output logic [2:0] gnt_o
);

`ifdef SNOOP_ARB_FIXED_PRIO_EN
  logic unused_ctrl;
  assign unused_ctrl = ^{clk_i, rst_i, advance_i};

  always_comb begin
    gnt_o = 3'b000;
    if (req_i[0]) begin
      gnt_o = 3'b001;
    end else if (req_i[1]) begin
      gnt_o = 3'b010;
    end else if (req_i[2]) begin
      gnt_o = 3'b100;
    end
  end
`else
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] idx;
  logic       found;

  // Search starts at the pointer and wraps modulo the cache count.
  always_comb begin
    gnt_o = 3'b000;
    found = 1'b0;
    idx   = 2'd0;
    for (int unsigned off = 0; off < NUM_CACHES; off++) begin
      idx = 2'((32'(ptr_q) + off) % NUM_CACHES);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      if (gnt_o[0]) begin
        ptr_d = 2'd1;
      end else if (gnt_o[1]) begin
        ptr_d = 2'd2;
      end else if (gnt_o[2]) begin
        ptr_d = 2'd0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= 2'd0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

endmodule

// File: rtl/snoop_bus_sequencer.sv
// Snooping-bus arbiter and transaction sequencer (IDLE/ADDR/SNOOP/WB/RESP).
// Arbitration policy selected by SNOOP_ARB_FIXED_PRIO_EN inside rr_arbiter3.
module snoop_bus_sequencer
  import snoop_bus_pkg::*;
#(
  parameter int unsigned AddrW = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [5:0]         req_msg_i,
  input  logic [3*AddrW-1:0] req_addr_i,
  input  logic [2:0]         wb_req_i,
  output logic [2:0]         grant_o,
  output logic [1:0]         bus_msg_o,
  output logic [AddrW-1:0]   bus_addr_o,
  output logic               mem_we_o,
  output logic [1:0]         wb_src_o,
  output logic [2:0]         done_o,
  output logic               proto_err_o
);

  state_e           state_q, state_d;
  msg_e             msg_q, msg_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic [2:0]       grant_q, grant_d;
  logic [1:0]       bus_msg_q, bus_msg_d;
  logic             mem_we_q, mem_we_d;
  logic [1:0]       wb_src_q, wb_src_d;
  logic [2:0]       done_q, done_d;
  logic             perr_q, perr_d;

  logic [2:0]       req_vld;
  logic [2:0]       win;
  logic [2:0]       snoop_hits;
  msg_e             win_msg;
  logic [AddrW-1:0] win_addr;

  always_comb begin
    req_vld  = 3'b000;
    win_msg  = MSG_EMPTY;
    win_addr = '0;
    for (int unsigned i = 0; i < NUM_CACHES; i++) begin
      req_vld[i] = |req_msg_i[2*i +: 2];
      if (win[i]) begin
        win_msg  = msg_e'(req_msg_i[2*i +: 2]);
        win_addr = req_addr_i[AddrW*i +: AddrW];
      end
    end
  end

  rr_arbiter3 u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_vld),
    .advance_i (state_q == StIdle),
    .gnt_o     (win)
  );

  // The grantee's own snoop response is never a write-back source.
  assign snoop_hits = wb_req_i & ~grant_q;

  always_comb begin
    state_d   = state_q;
    msg_d     = msg_q;
    addr_d    = addr_q;
    grant_d   = grant_q;
    bus_msg_d = MSG_EMPTY;
    mem_we_d  = 1'b0;
    wb_src_d  = wb_src_q;
    done_d    = 3'b000;
    perr_d    = perr_q;
    case (state_q)
      StIdle: begin
        if (|win) begin
          grant_d   = win;
          msg_d     = win_msg;
          addr_d    = win_addr;
          bus_msg_d = win_msg;
          state_d   = StAddr;
        end
      end
      StAddr: state_d = StSnoop;
      StSnoop: begin
        if (msg_q != MSG_INVALIDATE && |snoop_hits) begin
          wb_src_d = lowest_idx(snoop_hits);
          mem_we_d = 1'b1;
          state_d  = StWb;
          if ((snoop_hits & (snoop_hits - 3'd1)) != 3'b000) begin
            perr_d = 1'b1;
          end
        end else begin
          done_d  = grant_q;
          state_d = StResp;
        end
      end
      StWb: begin
        done_d  = grant_q;
        state_d = StResp;
      end
      StResp: begin
        grant_d = 3'b000;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      msg_q     <= MSG_EMPTY;
      addr_q    <= '0;
      grant_q   <= 3'b000;
      bus_msg_q <= 2'b00;
      mem_we_q  <= 1'b0;
      wb_src_q  <= 2'd0;
      done_q    <= 3'b000;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      msg_q     <= msg_d;
      addr_q    <= addr_d;
      grant_q   <= grant_d;
      bus_msg_q <= bus_msg_d;
      mem_we_q  <= mem_we_d;
      wb_src_q  <= wb_src_d;
      done_q    <= done_d;
      perr_q    <= perr_d;
    end
  end

  assign grant_o     = grant_q;
  assign bus_msg_o   = bus_msg_q;
  assign bus_addr_o  = addr_q;
  assign mem_we_o    = mem_we_q;
  assign wb_src_o    = wb_src_q;
  assign done_o      = done_q;
  assign proto_err_o = perr_q;

endmodule
